// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and sequencer for the multi-cycle divider.
// Holds divider operands stable for the whole run and stalls non-NOP commands while busy.
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_rs,
    input  logic [WIDTH-1:0]   cmd_rt,
    output logic               cmd_ack,
    input  logic               flush,
    output logic [WIDTH-1:0]   rd_data,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               div_start,
    output logic               div_signd,
    output logic [WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]   div_divider,
    input  logic               div_ready,
    input  logic [2*WIDTH-1:0] div_remquot
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divider;
    logic             r_signd;
    logic             w_accept;
    logic             w_capture;
    logic             w_nop_ack;

    assign w_nop_ack = cmd_valid && !flush && (cmd_op == OP_NOP);

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        cmd_ack   = 1'b0;
        rd_data   = '0;
        div_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && !flush) begin
                    cmd_ack  = 1'b1;
                    w_accept = 1'b1;
                    case (cmd_op)
                        OP_DIV, OP_DIVU: w_next  = S_START;
                        OP_MFHI:         rd_data = r_hi;
                        OP_MFLO:         rd_data = r_lo;
                        default:         ;
                    endcase
                end
            end
            S_START: begin
                cmd_ack = w_nop_ack;
                // A flush here cancels the launch before the divider ever sees it.
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    div_start = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                cmd_ack = w_nop_ack;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (div_ready) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dividend <= '0;
            r_divider  <= '0;
            r_signd    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                case (cmd_op)
                    OP_DIV, OP_DIVU: begin
                        r_dividend <= cmd_rs;
                        r_divider  <= cmd_rt;
                        r_signd    <= (cmd_op == OP_DIV);
                    end
                    OP_MTHI: r_hi <= cmd_rs;
                    OP_MTLO: r_lo <= cmd_rs;
                    default: ;
                endcase
            end
            if (w_capture) begin
                r_hi <= div_remquot[2*WIDTH-1:WIDTH];
                r_lo <= div_remquot[WIDTH-1:0];
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign div_signd    = r_signd;
    assign div_dividend = r_dividend;
    assign div_divider  = r_divider;

endmodule
